// File: rtl/pipelined_control.sv
// rtl/pipelined_control.sv - pipelined instruction control decoder with hazard, flush and halt handling
//
// Decodes opcode/mode into a packed control word and carries it through DEPTH
// register stages alongside valid, dst, halt and illegal bits.
// Optional macro CTRL_PERF_CNT_EN adds retired/bubble performance counters.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   instr_valid, opcode, mode        incoming instruction from fetch
//   src_a_addr, src_b_addr, dst_addr register addresses for the incoming instruction
//   stall_in, flush_in               downstream stall / taken-branch flush
//   ready_out                        incoming instruction consumed this cycle
//   ctrl_q, valid_q, illegal_q       output stage (stage DEPTH) control word and flags
//   done                             sticky, set when HALT retires
//   retired_cnt, bubble_cnt          (CTRL_PERF_CNT_EN only) performance counters
module pipelined_control #(
    parameter int DEPTH    = 2,
    parameter int OPCODE_W = 3,
    parameter int MODE_W   = 4,
    parameter int ALUOP_W  = 4,
    parameter int REG_AW   = 3,
    localparam int CW_W    = 12 + ALUOP_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [MODE_W-1:0]   mode,
    input  logic [REG_AW-1:0]   src_a_addr,
    input  logic [REG_AW-1:0]   src_b_addr,
    input  logic [REG_AW-1:0]   dst_addr,
    input  logic                stall_in,
    input  logic                flush_in,
    output logic                ready_out,
    output logic [CW_W-1:0]     ctrl_q,
    output logic                valid_q,
    output logic                illegal_q,
`ifdef CTRL_PERF_CNT_EN
    output logic [15:0]         retired_cnt,
    output logic [15:0]         bubble_cnt,
`endif
    output logic                done
);

    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_XOR   = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_LDST  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_ADI   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_SHIFT = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_BR    = OPCODE_W'(6);

    // Control word bit positions
    localparam int B_TRUNC_REG = 0;
    localparam int B_TRUNC_PFX = 1;
    localparam int B_ABS_BR    = 2;
    localparam int B_REL_BR    = 3;
    localparam int B_BR_INV    = 4;
    localparam int B_BR_FLAG   = 5;
    localparam int B_MEM_WR    = 6;
    localparam int B_REG_WR    = 7;
    localparam int B_MEM2REG   = 8;

    // Decode of the incoming instruction
    logic [CW_W-1:0] dec_cw;
    logic            dec_halt;
    logic            dec_ill;

    always_comb begin
        dec_cw             = '0;
        dec_halt           = 1'b0;
        dec_ill            = 1'b0;
        dec_cw[B_REG_WR]   = 1'b1;
        dec_cw[11:10]      = 2'b01;
        case (opcode)
            OP_ADD:  dec_cw[CW_W-1:12] = ALUOP_W'(4'b0000);
            OP_XOR:  dec_cw[CW_W-1:12] = ALUOP_W'(4'b0001);
            OP_AND:  dec_cw[CW_W-1:12] = ALUOP_W'(4'b0010);
            OP_LDST: begin
                dec_cw[CW_W-1:12]   = ALUOP_W'(4'b0001);
                dec_cw[B_TRUNC_REG] = 1'b1;
                dec_cw[11:10]       = 2'b00;
                if (mode[3]) begin
                    dec_cw[B_MEM_WR] = 1'b1;
                    dec_cw[B_REG_WR] = 1'b0;
                end else begin
                    dec_cw[B_MEM2REG] = 1'b1;
                end
            end
            OP_ADI: begin
                dec_cw[CW_W-1:12]   = ALUOP_W'(4'b0000);
                dec_cw[B_TRUNC_REG] = 1'b1;
                dec_cw[B_TRUNC_PFX] = 1'b1;
                dec_cw[11:10]       = 2'b10;
            end
            OP_SHIFT: begin
                case (mode[2:0])
                    3'b000:  dec_cw[CW_W-1:12] = ALUOP_W'(4'b0100);
                    3'b010:  dec_cw[CW_W-1:12] = ALUOP_W'(4'b0101);
                    3'b011:  dec_cw[CW_W-1:12] = ALUOP_W'(4'b0011);
                    3'b100:  dec_cw[CW_W-1:12] = ALUOP_W'(4'b0110);
                    3'b110:  dec_cw[CW_W-1:12] = ALUOP_W'(4'b0111);
                    default: dec_ill = 1'b1;
                endcase
            end
            OP_BR: begin
                dec_cw[B_REG_WR]  = 1'b0;
                dec_cw[B_ABS_BR]  = mode[0];
                dec_cw[B_REL_BR]  = ~mode[0];
                dec_cw[B_BR_FLAG] = mode[1];
                dec_cw[B_BR_INV]  = mode[2];
            end
            default: begin
                dec_cw[B_REG_WR] = 1'b0;
                dec_halt         = 1'b1;
            end
        endcase
        // An illegal encoding must never write anything downstream
        if (dec_ill) begin
            dec_cw[B_REG_WR] = 1'b0;
            dec_cw[B_MEM_WR] = 1'b0;
        end
    end

    // Pipeline stage state; index 0 is stage 1, index DEPTH-1 is the output stage
    logic [DEPTH-1:0]  stage_valid_q, stage_valid_d;
    logic [DEPTH-1:0]  stage_halt_q,  stage_halt_d;
    logic [DEPTH-1:0]  stage_ill_q,   stage_ill_d;
    logic [CW_W-1:0]   stage_cw_q  [DEPTH];
    logic [CW_W-1:0]   stage_cw_d  [DEPTH];
    logic [REG_AW-1:0] stage_dst_q [DEPTH];
    logic [REG_AW-1:0] stage_dst_d [DEPTH];
    logic              done_q, done_d;
    logic              hazard;

    // Load-use: stage 1 is a load whose result the incoming instruction reads.
    // src_b only matters when the incoming instruction uses a register second operand.
    assign hazard = stage_valid_q[0] && stage_cw_q[0][B_MEM2REG] && instr_valid &&
                    ((src_a_addr == stage_dst_q[0]) ||
                     ((src_b_addr == stage_dst_q[0]) && (dec_cw[11:10] == 2'b01)));

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_halt_d  = stage_halt_q;
        stage_ill_d   = stage_ill_q;
        stage_cw_d    = stage_cw_q;
        stage_dst_d   = stage_dst_q;
        ready_out     = 1'b0;
        done_d        = done_q | (stage_valid_q[DEPTH-1] & stage_halt_q[DEPTH-1]);

        if (flush_in) begin
            // Wrong-path work is killed; anything offered now is consumed and dropped
            stage_valid_d = '0;
            ready_out     = 1'b1;
        end else if (!stall_in) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                stage_valid_d[i] = stage_valid_q[i-1];
                stage_halt_d[i]  = stage_halt_q[i-1];
                stage_ill_d[i]   = stage_ill_q[i-1];
                stage_cw_d[i]    = stage_cw_q[i-1];
                stage_dst_d[i]   = stage_dst_q[i-1];
            end
            ready_out        = !done_q && !hazard;
            stage_valid_d[0] = instr_valid && ready_out;
            stage_halt_d[0]  = dec_halt;
            stage_ill_d[0]   = dec_ill;
            stage_cw_d[0]    = dec_cw;
            stage_dst_d[0]   = dst_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid_q <= '0;
            stage_halt_q  <= '0;
            stage_ill_q   <= '0;
            done_q        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stage_cw_q[i]  <= '0;
                stage_dst_q[i] <= '0;
            end
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_halt_q  <= stage_halt_d;
            stage_ill_q   <= stage_ill_d;
            done_q        <= done_d;
            stage_cw_q    <= stage_cw_d;
            stage_dst_q   <= stage_dst_d;
        end
    end

    assign valid_q   = stage_valid_q[DEPTH-1];
    assign ctrl_q    = valid_q ? stage_cw_q[DEPTH-1] : '0;
    assign illegal_q = valid_q & stage_ill_q[DEPTH-1];
    assign done      = done_q;

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired_cnt_q, retired_cnt_d;
    logic [15:0] bubble_cnt_q,  bubble_cnt_d;

    always_comb begin
        retired_cnt_d = retired_cnt_q;
        bubble_cnt_d  = bubble_cnt_q;
        if (!stall_in) begin
            if (valid_q) begin
                retired_cnt_d = retired_cnt_q + 16'd1;
            end else if (!done_q) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt_q <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign bubble_cnt  = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_control.sv
// tb/tb_pipelined_control.sv - directed self-checking bench for pipelined_control
module tb_pipelined_control;

    localparam logic [2:0] ADD = 3'd0, XOR = 3'd1, AND_ = 3'd2, LDST = 3'd3;
    localparam logic [2:0] ADI = 3'd4, SHF = 3'd5, BR = 3'd6, HALT = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [2:0]  opcode;
    logic [3:0]  mode;
    logic [2:0]  src_a_addr, src_b_addr, dst_addr;
    logic        stall_in, flush_in;
    logic        ready_out;
    logic [15:0] ctrl_q;
    logic        valid_q, illegal_q, done;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired_cnt, bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_control #(.DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .mode        (mode),
        .src_a_addr  (src_a_addr),
        .src_b_addr  (src_b_addr),
        .dst_addr    (dst_addr),
        .stall_in    (stall_in),
        .flush_in    (flush_in),
        .ready_out   (ready_out),
        .ctrl_q      (ctrl_q),
        .valid_q     (valid_q),
        .illegal_q   (illegal_q),
`ifdef CTRL_PERF_CNT_EN
        .retired_cnt (retired_cnt),
        .bubble_cnt  (bubble_cnt),
`endif
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic put(input logic iv, input logic [2:0] op, input logic [3:0] md,
                       input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] dd);
        instr_valid = iv;
        opcode      = op;
        mode        = md;
        src_a_addr  = sa;
        src_b_addr  = sb;
        dst_addr    = dd;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset    = 1'b1;
        stall_in = 1'b0;
        flush_in = 1'b0;
        put(0, ADD, 0, 0, 0, 0);
        #12;
        chk("rst_valid", valid_q, 0);
        chk("rst_ctrl", ctrl_q, 0);
        chk("rst_illegal", illegal_q, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ready_out, 1);
`ifdef CTRL_PERF_CNT_EN
        chk("rst_retired", retired_cnt, 0);
        chk("rst_bubble", bubble_cnt, 0);
`endif
        reset = 1'b0;

        // ADD then STO, one cycle apart, latency DEPTH-1
        put(1, ADD, 4'b0000, 1, 2, 4);
        #1 chk("add_ready", ready_out, 1);
        tick(); chk("add_lat_valid", valid_q, 0);
        put(1, LDST, 4'b1000, 1, 2, 5);
        tick(); chk("add_cw", ctrl_q, 16'h0480); chk("add_valid", valid_q, 1);
        put(0, ADD, 0, 0, 0, 0);
        tick(); chk("sto_cw", ctrl_q, 16'h1041); chk("sto_valid", valid_q, 1);
        tick(); chk("drain_valid", valid_q, 0); chk("drain_cw", ctrl_q, 0);

        // Load-use on src_a: one bubble, no duplicate
        put(1, LDST, 4'b0000, 1, 2, 3);
        tick();
        put(1, ADD, 4'b0000, 3, 5, 4);
        #1 chk("hz_ready0", ready_out, 0);
        tick(); chk("lod_cw", ctrl_q, 16'h1181);
        #1 chk("hz_ready1", ready_out, 1);
        tick(); chk("hz_bub_valid", valid_q, 0); chk("hz_bub_cw", ctrl_q, 0);
        put(0, ADD, 0, 0, 0, 0);
        tick(); chk("hz_add_cw", ctrl_q, 16'h0480);
        tick(); chk("hz_nodup", valid_q, 0);

        // src_b only counts when the second operand is a register
        put(1, LDST, 4'b0000, 0, 0, 3);
        tick();
        put(1, ADI, 4'b0000, 0, 3, 1);
        #1 chk("hz_adi_ready", ready_out, 1);
        tick();
        put(1, LDST, 4'b0000, 0, 0, 6);
        tick(); chk("adi_cw", ctrl_q, 16'h0883);
        put(1, XOR, 4'b0000, 0, 6, 1);
        #1 chk("hz_srcb_ready", ready_out, 0);
        put(0, ADD, 0, 0, 0, 0);
        tick(); chk("lod6_cw", ctrl_q, 16'h1181);
        tick(); tick(); chk("srcb_drain", valid_q, 0);

        // Flush with two in flight; the instruction offered with it is dropped
        put(1, ADD, 0, 0, 0, 1); tick();
        put(1, XOR, 0, 0, 0, 2); tick(); chk("fl_pre_cw", ctrl_q, 16'h0480);
        put(1, AND_, 0, 0, 0, 3);
        flush_in = 1'b1; stall_in = 1'b1;
        #1 chk("fl_ready", ready_out, 1);
        tick(); chk("fl_valid0", valid_q, 0);
        flush_in = 1'b0; stall_in = 1'b0;
        put(0, ADD, 0, 0, 0, 0);
        tick(); chk("fl_valid1", valid_q, 0);
        tick(); chk("fl_valid2", valid_q, 0);

        // Stall for three cycles mid-stream
        put(1, ADD, 0, 0, 0, 1); tick();
        put(1, XOR, 0, 0, 0, 2); tick(); chk("st_pre_cw", ctrl_q, 16'h0480);
        put(1, AND_, 0, 0, 0, 3);
        stall_in = 1'b1;
        #1 chk("st_ready0", ready_out, 0);
        for (int k = 0; k < 3; k++) begin
            tick(); chk("st_hold_cw", ctrl_q, 16'h0480); chk("st_hold_valid", valid_q, 1);
        end
        stall_in = 1'b0;
        #1 chk("st_ready1", ready_out, 1);
        tick(); chk("st_xor_cw", ctrl_q, 16'h1480);
        put(0, ADD, 0, 0, 0, 0);
        tick(); chk("st_and_cw", ctrl_q, 16'h2480);
        tick(); chk("st_drain", valid_q, 0);

        // Illegal shift, legal shift, branch
        put(1, SHF, 4'b0001, 0, 0, 1); tick();
        put(1, SHF, 4'b0011, 0, 0, 1); tick();
        chk("ill_q", illegal_q, 1); chk("ill_regwr", ctrl_q[7], 0);
        chk("ill_memwr", ctrl_q[6], 0); chk("ill_valid", valid_q, 1);
        put(1, BR, 4'b0101, 0, 0, 0);
        tick(); chk("shf_cw", ctrl_q, 16'h3480); chk("shf_ill", illegal_q, 0);
        put(1, BR, 4'b0010, 0, 0, 0);
        tick(); chk("br_abs_cw", ctrl_q, 16'h0414);
        put(0, ADD, 0, 0, 0, 0);
        tick(); chk("br_rel_cw", ctrl_q, 16'h0428);
        tick();

        // HALT retires, done sticks, then reset clears it immediately
        put(1, HALT, 0, 0, 0, 0); tick();
        put(0, ADD, 0, 0, 0, 0);
        tick(); chk("halt_cw", ctrl_q, 16'h0400); chk("halt_done0", done, 0);
        tick(); chk("halt_done1", done, 1);
        put(1, ADD, 0, 0, 0, 1);
        #1 chk("done_ready", ready_out, 0);
        tick(); chk("done_bub0", valid_q, 0);
        tick(); chk("done_bub1", valid_q, 0); chk("done_sticky", done, 1);
        reset = 1'b1;
        #1 chk("mid_rst_done", done, 0); chk("mid_rst_valid", valid_q, 0);
        chk("mid_rst_ready", ready_out, 1);
        reset = 1'b0;
        tick(); tick(); chk("post_rst_cw", ctrl_q, 16'h0480);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_control.md
Name: pipelined_control

Overview:
Parametrised successor to the single-cycle control decoder. It decodes the 9-bit instruction's opcode/mode into a packed control word and carries it through DEPTH pipeline register stages with valid bits. It adds stall, branch flush, load-use interlock, HALT detection and illegal-encoding detection. It sits between fetch and the execute/writeback datapath of the pipelined core.

Parameters:
DEPTH, 2, number of control register stages (>=1); output taken from stage DEPTH
OPCODE_W, 3, opcode field width
MODE_W, 4, mode field width
ALUOP_W, 4, ALU operation code width
REG_AW, 3, register address width for hazard compare
CW_W, 12+ALUOP_W, packed control word width (derived, not overridden)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
instr_valid  input  1  fetch presents an instruction this cycle
opcode  input  OPCODE_W  instruction opcode (instr[8:6])
mode  input  MODE_W  instruction mode bits
src_a_addr  input  REG_AW  resolved first-operand register address
src_b_addr  input  REG_AW  resolved second-operand register address
dst_addr  input  REG_AW  resolved destination register address
stall_in  input  1  downstream stall; freezes all stages
flush_in  input  1  taken branch resolved; kill wrong-path work
ready_out  output  1  incoming instruction consumed this cycle
ctrl_q  output  CW_W  control word of stage DEPTH, gated by its valid
valid_q  output  1  stage DEPTH holds a live instruction
illegal_q  output  1  stage DEPTH holds an illegal encoding
done  output  1  sticky: HALT retired

Behaviour:
- Reset (async, high): all stage valids, ctrl_q, valid_q, illegal_q and done are 0. ready_out is combinational and equals 1 out of reset unless stall_in is high.
- Control word bit order: 0 TruncatedReg, 1 TruncPrefix, 2 AbsBranch, 3 RelBranch, 4 BranchInvert, 5 BranchFlag, 6 MemWrite, 7 RegWrite, 8 MemtoReg, 9 ParityOp, [11:10] SecondOperand, [CW_W-1:12] ALUOp.
- Decode defaults: RegWrite=1, SecondOperand=01, everything else 0.
  - Opcode 000: ADD, ALUOp 0000.
  - Opcode 001: XOR, ALUOp 0001.
  - Opcode 010: AND, ALUOp 0010.
  - Opcode 011: LOD/STO. ALUOp 0001, TruncatedReg=1, TruncPrefix=0, SecondOperand=00. mode[3]=0 gives MemtoReg=1. mode[3]=1 gives MemWrite=1 and RegWrite=0.
  - Opcode 100: ADI. ALUOp 0000, TruncatedReg=1, TruncPrefix=1, SecondOperand=10.
  - Opcode 101: shift. mode[2:0] maps 000->0100, 010->0101, 011->0011, 100->0110, 110->0111. Any other mode[2:0] is illegal.
  - Opcode 110: branch. RegWrite=0, AbsBranch=mode[0], RelBranch=~mode[0], BranchFlag=mode[1], BranchInvert=mode[2].
  - Opcode 111: HALT. RegWrite=0; a halt bit is carried with the stage.
- Illegal encodings carry the illegal bit, with RegWrite=0 and MemWrite=0.
- Latency: an instruction accepted at edge N appears on ctrl_q/valid_q after edge N+DEPTH-1. Each stage carries valid, control word, dst_addr, halt and illegal bits.
- ctrl_q is all-zero whenever valid_q=0 (bubble).
- Priority per edge: reset > flush_in > stall_in > done > load-use hazard > normal advance.
  - flush_in=1: every stage valid is cleared. If instr_valid=1, the incoming instruction is consumed and dropped (ready_out=1). flush_in overrides stall_in.
  - stall_in=1: all stages hold; ready_out=0.
  - done=1: no further instructions are accepted; ready_out=0; stages drain as bubbles.
  - Load-use hazard:
    - Condition: stage 1 valid, its MemtoReg=1, and instr_valid=1.
    - Match: src_a_addr equals stage-1 dst, or src_b_addr equals it while the incoming SecondOperand is 01.
    - Response: stages advance, a bubble enters stage 1, ready_out=0, and the same instruction must be re-presented.
- HALT: when valid HALT occupies stage DEPTH at an edge, done becomes 1 at that edge and stays 1 until reset. ctrl_q for the HALT shows RegWrite=0.
- illegal_q = valid_q & illegal bit. The instruction otherwise behaves as a bubble (no writes).
- DEPTH=1: stage 1 is the output stage. Hazard and flush rules are unchanged.

Optional Feature:
CTRL_PERF_CNT_EN.
- Defined: adds outputs retired_cnt[15:0] and bubble_cnt[15:0], both reset to 0.
  - retired_cnt increments when valid_q=1 and stall_in=0.
  - bubble_cnt increments when valid_q=0, stall_in=0 and done=0.
  - Both counters wrap at 16'hFFFF->0 and hold while stall_in=1.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Test Plan:
- DEPTH=2, ADD (opcode 000) then STO (011, mode 1000) -> ctrl_q shows RegWrite=1/ALUOp 0000, then MemWrite=1/RegWrite=0/SecondOperand=00, each valid one cycle apart, first appearing 1 cycle after accept.
- LOD dst=3 followed by ADD src_a=3 -> ready_out=0 for one cycle, one bubble (valid_q=0, ctrl_q=0), then ADD issues with no duplicate.
- Two instructions in flight, flush_in=1 for one cycle -> next DEPTH cycles valid_q=0; instruction presented with the flush is dropped.
- stall_in=1 for 3 cycles mid-stream -> ctrl_q and valid_q constant, ready_out=0; stream resumes in order.
- Shift mode 001 -> illegal_q=1 with RegWrite=0. HALT (111) -> done=1 at the edge after it reaches stage DEPTH, ready_out=0 thereafter; reset mid-run clears done and all valids immediately.
- With CTRL_PERF_CNT_EN: 5 instructions plus 1 hazard bubble -> retired_cnt=5, bubble_cnt counts the bubble and the fill/drain cycles.
